// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: stall/flush controls for PC, IF/ID, ID/EX and EX/MA,
// sequencing mispredict flush, external halt and data-memory timeout.
module hazard_sched #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic             id_need_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_need_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_rf_we,
  input  logic             ex_mispredict,
  input  logic             ma_mem_req,
  input  logic             ma_mem_ready,
  input  logic             halt_req,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exma_stall,
  output logic             mem_err,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      wait_q, wait_d;
  logic [31:0]      fcyc_q, fcyc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             count_flush;
  logic             load_use, mem_wait, mispred;

  assign load_use = ex_valid & ex_is_load & ex_rf_we & (ex_rd != 5'd0) & id_valid &
                    ((id_need_rs1 & (id_rs1 == ex_rd)) | (id_need_rs2 & (id_rs2 == ex_rd)));
  assign mem_wait = ma_mem_req & ~ma_mem_ready;
  assign mispred  = ex_valid & ex_mispredict;

  assign mem_err   = mem_err_q;
  assign state_dbg = {1'b0, state_q};
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Control outputs and next-state / counter computation
  always_comb begin
    state_d     = state_q;
    wait_d      = 32'd0;
    fcyc_d      = fcyc_q;
    count_flush = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exma_stall  = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
      fcyc_d     = 32'd0;
    end else if (state_q == ST_ERR) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      exma_stall = 1'b1;
    end else if (mem_wait) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      exma_stall = 1'b1;
      if (wait_q == 32'hFFFF_FFFF) begin
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + 32'd1;
      end
      if ((MEM_TIMEOUT != 32'd0) && (wait_d == 32'(MEM_TIMEOUT))) begin
        state_d = ST_ERR;
      end else begin
        state_d = state_q;
      end
    end else if (mispred) begin
      // Redirect proceeds: PC is not held while the wrong-path fetches are squashed
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      count_flush = 1'b1;
      if (FLUSH_CYCLES != 32'd0) begin
        state_d = ST_FLUSH;
        fcyc_d  = 32'(FLUSH_CYCLES);
      end else begin
        state_d = ST_RUN;
        fcyc_d  = 32'd0;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (fcyc_q <= 32'd1) begin
            state_d = ST_RUN;
            fcyc_d  = 32'd0;
          end else begin
            fcyc_d  = fcyc_q - 32'd1;
          end
        end
        ST_RUN, ST_HALT: begin
          if (load_use | halt_req) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else begin
            pc_stall   = 1'b0;
          end
          // A load-use bubble in RUN defers the halt by one cycle
          if (state_q == ST_HALT) begin
            state_d = halt_req ? ST_HALT : ST_RUN;
          end else begin
            state_d = (halt_req & ~load_use) ? ST_HALT : ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (count_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    mem_err_d = mem_err_q | (state_d == ST_ERR);
  end

  // State, counters and sticky error register with synchronous reset
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= 32'd0;
      fcyc_q      <= 32'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      fcyc_q      <= fcyc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

endmodule
